xor_parity_pipe_using_mux: RTL and testbench

- Parametrised, pipelined XOR-reduction (parity) unit.
- The data path is built only from 2:1 mux cells, each wired as a 2-input XOR (sel = b, d0 = a, d1 = ~a), arranged as a binary tree with one register rank per tree level.
- A packet accumulator at the tree output folds per-beat parity across multi-beat packets, selects even or odd parity, and counts beats.
- Sits between a valid/ready producer and consumer as a drop-in integrity/checksum stage.

---
 rtl/xor_parity_pipe_using_mux_if.sv | 31 +++
 rtl/xor_parity_pipe_using_mux.sv | 134 +++++++++++++
 tb/tb_xor_parity_pipe_using_mux.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/xor_parity_pipe_using_mux_if.sv
// Purpose: valid/ready bundle for the pipelined parity unit (producer side in, result side out).
// Latency: n/a (signal bundle only).
// Backpressure: in_ready is driven by the unit; out_ready is driven by the consumer.
//
// Ports (slave = parity unit, master = producer/consumer):
//   in_valid/in_ready/in_data/in_last/in_odd  beat input handshake
//   out_valid/out_ready/out_parity/out_beats  packet result handshake
interface xor_parity_pipe_using_mux_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             in_odd;
  logic             out_valid;
  logic             out_ready;
  logic             out_parity;
  logic [CNT_W-1:0] out_beats;

  modport master (
    output in_valid, in_data, in_last, in_odd, out_ready,
    input  in_ready, out_valid, out_parity, out_beats
  );

  modport slave (
    input  in_valid, in_data, in_last, in_odd, out_ready,
    output in_ready, out_valid, out_parity, out_beats
  );
endinterface

// File: rtl/xor_parity_pipe_using_mux.sv
// Purpose: pipelined XOR-reduction of each beat via a 2:1-mux tree, folded into per-packet parity.
// Latency: LEVELS tree registers + 1 output register (single-beat packet: LEVELS+1 edges).
// Backpressure: one global enable; while a result waits unconsumed the whole pipe freezes and in_ready=0.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset (0 = reset)
//   bus  slave side of xor_parity_pipe_using_mux_if (beat input + packet result)

// 2:1 mux cell; the tree wires it as an XOR (sel = b, d0 = a, d1 = ~a).
module xor_parity_pipe_using_mux_cell (
  input  logic d0,
  input  logic d1,
  input  logic sel,
  output logic y
);
  assign y = sel ? d1 : d0;
endmodule

module xor_parity_pipe_using_mux #(
  parameter  int WIDTH  = 8,              // must be >= 2
  parameter  int CNT_W  = 8,
  localparam int LEVELS = $clog2(WIDTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  xor_parity_pipe_using_mux_if.slave   bus
);

  localparam int PW = 1 << LEVELS;  // padded tree width

  logic en;

  // Tree storage: all registered levels packed flat, level 1 at the bottom.
  // node[] prepends the padded input so every level reads its source uniformly.
  logic [PW-1:0]     pad;
  logic [PW-2:0]     tree_d, tree_q;
  logic [2*PW-2:0]   node;

  logic [LEVELS:1]   vld_q, last_q, odd_q;

  logic              p;
  logic [CNT_W-1:0]  cnt_inc;
  logic              acc_d, acc_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic              out_valid_d, out_valid_q;
  logic              out_parity_d, out_parity_q;
  logic [CNT_W-1:0]  out_beats_d, out_beats_q;

  // Advance only when the output slot is empty or being drained this edge.
  assign en           = !out_valid_q || bus.out_ready;
  assign bus.in_ready = en;

  assign pad  = PW'(bus.in_data);
  assign node = {tree_q, pad};

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int N   = PW >> k;
    localparam int DST = PW - (PW >> (k - 1));  // offset of level k inside tree_d
    localparam int SRC = PW + DST - 2 * N;      // offset of level k-1 inside node
    for (genvar i = 0; i < N; i++) begin : g_cell
      xor_parity_pipe_using_mux_cell u_cell (
        .d0  (node[SRC + 2*i]),
        .d1  (~node[SRC + 2*i]),
        .sel (node[SRC + 2*i + 1]),
        .y   (tree_d[DST + i])
      );
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tree_q <= '0;
      vld_q  <= '0;
      last_q <= '0;
      odd_q  <= '0;
    end else if (en) begin
      tree_q    <= tree_d;
      vld_q[1]  <= bus.in_valid;
      last_q[1] <= bus.in_last;
      odd_q[1]  <= bus.in_odd;
      for (int k = 2; k <= LEVELS; k++) begin
        vld_q[k]  <= vld_q[k-1];
        last_q[k] <= last_q[k-1];
        odd_q[k]  <= odd_q[k-1];
      end
    end
  end

  // Root of the tree is the parity of the beat leaving the last stage.
  assign p       = node[2*PW-2];
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    out_valid_d  = 1'b0;
    out_parity_d = out_parity_q;
    out_beats_d  = out_beats_q;
    if (vld_q[LEVELS]) begin
      if (last_q[LEVELS]) begin
        out_parity_d = acc_q ^ p ^ odd_q[LEVELS];
        out_beats_d  = cnt_inc;
        out_valid_d  = 1'b1;
        acc_d        = 1'b0;
        cnt_d        = '0;
      end else begin
        acc_d = acc_q ^ p;
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q        <= 1'b0;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      out_parity_q <= 1'b0;
      out_beats_q  <= '0;
    end else if (en) begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      out_parity_q <= out_parity_d;
      out_beats_q  <= out_beats_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_parity = out_parity_q;
  assign bus.out_beats  = out_beats_q;

endmodule

// File: tb/tb_xor_parity_pipe_using_mux.sv
// Purpose: scoreboard bench for the mux-tree parity pipe (8-bit/8-bit-count and 5-bit/2-bit-count builds).
// Latency: expects results LEVELS+1 edges after the last beat when unstalled.
// Backpressure: drives out_ready low on the 8-bit build to check freeze and in-order drain.
module tb_xor_parity_pipe_using_mux;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  xor_parity_pipe_using_mux_if #(.WIDTH(8), .CNT_W(8)) b8 ();
  xor_parity_pipe_using_mux_if #(.WIDTH(5), .CNT_W(2)) b5 ();

  xor_parity_pipe_using_mux #(.WIDTH(8), .CNT_W(8)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (b8.slave)
  );

  xor_parity_pipe_using_mux #(.WIDTH(5), .CNT_W(2)) u_dut5 (
    .clk (clk),
    .rst (rst),
    .bus (b5.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int got8 = 0, exp8 = 0, got5 = 0, exp5 = 0;

  logic [8:0] q8[$];   // {parity, beats[7:0]}
  logic [2:0] q5[$];   // {parity, beats[1:0]}
  logic [8:0] e8;
  logic [2:0] e5;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitors: pop one expectation per completed result handshake.
  always @(negedge clk) begin
    if (rst && b8.out_valid && b8.out_ready) begin
      got8++;
      check("dut8_result_expected", q8.size() != 0, 1);
      if (q8.size() != 0) begin
        e8 = q8.pop_front();
        check("dut8_parity", b8.out_parity, e8[8]);
        check("dut8_beats", b8.out_beats, e8[7:0]);
      end
    end
  end

  always @(negedge clk) begin
    if (rst && b5.out_valid && b5.out_ready) begin
      got5++;
      check("dut5_result_expected", q5.size() != 0, 1);
      if (q5.size() != 0) begin
        e5 = q5.pop_front();
        check("dut5_parity", b5.out_parity, e5[2]);
        check("dut5_beats", b5.out_beats, e5[1:0]);
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) sync();
  endtask

  // Offer one beat; ep/eb are the hand-computed packet result, queued when a last beat is taken.
  task automatic send(input bit d5, input logic [7:0] d, input bit l, input bit o,
                      input bit ep, input logic [7:0] eb);
    bit r;
    int n;
    if (d5) begin
      b5.in_valid = 1'b1; b5.in_data = d[4:0]; b5.in_last = l; b5.in_odd = o;
    end else begin
      b8.in_valid = 1'b1; b8.in_data = d;      b8.in_last = l; b8.in_odd = o;
    end
    r = 1'b0;
    n = 0;
    while (!r && n < 200) begin
      @(negedge clk);
      r = d5 ? b5.in_ready : b8.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (d5) begin
      check("dut5_accept", r, 1);
      b5.in_valid = 1'b0;
      if (l && r) begin q5.push_back({ep, eb[1:0]}); exp5++; end
    end else begin
      check("dut8_accept", r, 1);
      b8.in_valid = 1'b0;
      if (l && r) begin q8.push_back({ep, eb}); exp8++; end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    b8.in_valid = 1'b0; b8.in_data = '0; b8.in_last = 1'b0; b8.in_odd = 1'b0; b8.out_ready = 1'b1;
    b5.in_valid = 1'b0; b5.in_data = '0; b5.in_last = 1'b0; b5.in_odd = 1'b0; b5.out_ready = 1'b1;
    #12;
    check("reset_out_valid", b8.out_valid, 0);
    check("reset_out_parity", b8.out_parity, 0);
    check("reset_out_beats", b8.out_beats, 0);
    @(negedge clk);
    rst = 1'b1;
    sync();
    check("post_reset_in_ready", b8.in_ready, 1);

    // Single beat A5 (4 ones): parity 0, result after edge 3.
    send(0, 8'hA5, 1, 0, 0, 8'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("latency_a5_out_valid", b8.out_valid, (i == 3));
    end
    idle(2);
    send(0, 8'h07, 1, 0, 1, 8'd1);
    idle(6);

    // Three-beat packet 01,03,80 odd: bits total 4 -> 0, ^1 -> 1, 3 beats.
    send(0, 8'h01, 0, 1, 0, 8'd0);
    send(0, 8'h03, 0, 1, 0, 8'd0);
    send(0, 8'h80, 1, 1, 1, 8'd3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("packet3_out_valid", b8.out_valid, (i == 3));
    end
    idle(2);

    // Back-to-back words FF, FE, 00 -> 0, 1, 0 on consecutive cycles.
    send(0, 8'hFF, 1, 0, 0, 8'd1);
    send(0, 8'hFE, 1, 0, 1, 8'd1);
    send(0, 8'h00, 1, 0, 0, 8'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("b2b_out_valid", b8.out_valid, (i >= 1 && i <= 3));
    end
    idle(2);

    // Backpressure: first result (1,1) stalls; later beats freeze in the tree.
    b8.out_ready = 1'b0;
    send(0, 8'h01, 1, 0, 1, 8'd1);
    fork
      begin
        send(0, 8'h01, 1, 1, 0, 8'd1);
        send(0, 8'h01, 0, 0, 0, 8'd0);
        send(0, 8'h01, 1, 0, 0, 8'd2);
        send(0, 8'h03, 1, 1, 1, 8'd1);
        send(0, 8'h01, 1, 0, 1, 8'd1);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check("stall_in_ready", b8.in_ready, 0);
          check("stall_out_valid", b8.out_valid, 1);
          check("stall_out_parity", b8.out_parity, 1);
          check("stall_out_beats", b8.out_beats, 1);
        end
        @(posedge clk);
        #1;
        b8.out_ready = 1'b1;
      end
    join
    idle(10);

    // Reset after one beat has been folded into the accumulator.
    send(0, 8'h01, 0, 0, 0, 8'd0);
    idle(5);
    #2;
    rst = 1'b0;
    #1;
    check("midreset_out_valid", b8.out_valid, 0);
    check("midreset_out_parity", b8.out_parity, 0);
    check("midreset_out_beats", b8.out_beats, 0);
    @(negedge clk);
    rst = 1'b1;
    sync();
    check("midreset_in_ready", b8.in_ready, 1);
    send(0, 8'h01, 1, 0, 1, 8'd1);
    idle(8);

    // 5-bit build (padded to 8), 2-bit saturating counter.
    send(1, 8'h15, 1, 0, 1, 8'd1);   // 10101 -> 1
    send(1, 8'h18, 1, 0, 0, 8'd1);   // 11000 -> 0
    for (int i = 0; i < 5; i++)      // five 00001 beats -> parity 1, beats saturate at 3
      send(1, 8'h01, (i == 4), 0, 1, 8'd3);
    for (int i = 0; i < 3; i++)      // three 00011 beats -> parity 0, beats 3
      send(1, 8'h03, (i == 2), 0, 0, 8'd3);
    send(1, 8'h10, 0, 1, 0, 8'd0);   // 10000, 00000, odd -> 1^1 = 0, beats 2
    send(1, 8'h00, 1, 1, 0, 8'd2);
    idle(10);

    check("dut8_queue_drained", q8.size(), 0);
    check("dut8_result_count", got8, exp8);
    check("dut5_queue_drained", q5.size(), 0);
    check("dut5_result_count", got5, exp5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
